// File: rtl/tacky_fpu_pkg.sv
// Shared opcodes, float constants and 16-bit float helpers (1 sign, 8 exponent, 7 mantissa).
// The reciprocal helper exists only when FPU_ARB_DIV_EN is defined.
package tacky_fpu_pkg;
    localparam int FLOAT   = 16;
    localparam int LAT_DEF = 1;

    typedef logic [FLOAT-1:0] float_t;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_DIV = 3'd3,
        OP_SHIFT = 3'd4, OP_SLT = 3'd5, OP_I2F = 3'd6, OP_F2I = 3'd7
    } op_t;

    localparam float_t FZERO  = 16'h0000;
    localparam float_t F32767 = 16'h7fff;  // saturated integer result of f2i
    localparam float_t F32768 = 16'h4700;  // first float magnitude that f2i saturates

    // Zero flush on exponent underflow, largest finite value on overflow.
    function automatic float_t fpack(input logic s, input logic signed [9:0] e, input logic [6:0] m);
        if (e <= 10'sd0) return FZERO;
        else if (e >= 10'sd255) return {s, 15'h7f7f};
        else return {s, e[7:0], m};
    endfunction

    function automatic float_t fadd(input float_t a, input float_t b);
        float_t x, y;
        logic [11:0] mx, my, s;
        logic [7:0] d;
        logic signed [9:0] e;
        if (a[14:7] == 8'd0) return (b[14:7] == 8'd0) ? FZERO : b;
        if (b[14:7] == 8'd0) return a;
        if (a[14:0] >= b[14:0]) begin x = a; y = b; end
        else begin x = b; y = a; end
        d  = x[14:7] - y[14:7];
        mx = {1'b0, 1'b1, x[6:0], 3'b000};
        my = (d > 8'd10) ? 12'd0 : ({1'b0, 1'b1, y[6:0], 3'b000} >> d);
        e  = signed'({2'b00, x[14:7]});
        s  = (x[15] == y[15]) ? (mx + my) : (mx - my);
        if (s == 12'd0) return FZERO;
        if (s[11]) begin s = s >> 1; e = e + 10'sd1; end
        for (int i = 0; i < 10; i++) begin
            if (!s[10]) begin s = s << 1; e = e - 10'sd1; end
        end
        return fpack(x[15], e, s[9:3]);
    endfunction

    function automatic float_t fmul(input float_t a, input float_t b);
        logic [15:0] p;
        logic signed [9:0] e;
        if (a[14:7] == 8'd0 || b[14:7] == 8'd0) return FZERO;
        p = {8'd0, 1'b1, a[6:0]} * {8'd0, 1'b1, b[6:0]};
        e = signed'({2'b00, a[14:7]}) + signed'({2'b00, b[14:7]}) - 10'sd127;
        if (p[15]) return fpack(a[15] ^ b[15], e + 10'sd1, p[14:8]);
        return fpack(a[15] ^ b[15], e, p[13:7]);
    endfunction

`ifdef FPU_ARB_DIV_EN
    function automatic float_t frecip(input float_t b);
        logic [16:0] q;
        if (b[14:7] == 8'd0) return {b[15], 15'h7f7f};
        if (b[6:0] == 7'd0) return fpack(b[15], 10'sd254 - signed'({2'b00, b[14:7]}), 7'd0);
        q = 17'h10000 / {9'd0, 1'b1, b[6:0]};
        return fpack(b[15], 10'sd253 - signed'({2'b00, b[14:7]}), q[7:1]);
    endfunction
`endif

    function automatic float_t fshift(input float_t a, input logic [15:0] b);
        logic signed [17:0] e;
        if (a[14:7] == 8'd0) return FZERO;
        e = signed'({10'd0, a[14:7]}) + signed'({{2{b[15]}}, b});
        if (e <= 18'sd0) return FZERO;
        if (e >= 18'sd255) return {a[15], 15'h7f7f};
        return {a[15], e[7:0], a[6:0]};
    endfunction

    // Monotonic unsigned key; both zeros map to the same key.
    function automatic logic [15:0] fkey(input float_t x);
        if (x[14:7] == 8'd0) return 16'h8000;
        return x[15] ? ~x : {1'b1, x[14:0]};
    endfunction

    function automatic float_t fslt(input float_t a, input float_t b);
        return (fkey(a) < fkey(b)) ? 16'h0001 : FZERO;
    endfunction

    function automatic float_t i2f(input logic [15:0] b);
        logic [15:0] v;
        logic [7:0] e;
        if (b == 16'd0) return FZERO;
        v = b[15] ? (~b + 16'd1) : b;
        e = 8'd142;
        for (int i = 0; i < 15; i++) begin
            if (!v[15]) begin v = v << 1; e = e - 8'd1; end
        end
        return {b[15], e, v[14:8]};
    endfunction

    function automatic float_t f2i(input float_t b);
        logic [23:0] v;
        if (b[15] || b[14:7] < 8'd127) return FZERO;
        if (b[14:0] >= F32768[14:0]) return F32767;
        v = {16'd0, 1'b1, b[6:0]} << (b[14:7] - 8'd127);
        return v[22:7];
    endfunction
endpackage

// File: rtl/fpu_core.sv
// Combinational op-select over the shared float units; FPU_ARB_DIV_EN adds the
// reciprocal / multiply-by-reciprocal divide passes.
module fpu_core
    import tacky_fpu_pkg::*;
(
    input  logic [2:0]       op,
    input  logic [FLOAT-1:0] a,
    input  logic [FLOAT-1:0] b,
`ifdef FPU_ARB_DIV_EN
    input  logic             div2,
    input  logic [FLOAT-1:0] recip,
`endif
    output logic [FLOAT-1:0] res
);
    // Result mux; the divide first pass yields recip(b), the second a*recip.
    always_comb begin
        res = FZERO;
        case (op)
            OP_ADD:   res = fadd(a, b);
            OP_SUB:   res = fadd(a, b ^ 16'h8000);
            OP_MUL:   res = fmul(a, b);
`ifdef FPU_ARB_DIV_EN
            OP_DIV:   res = div2 ? fmul(a, recip) : frecip(b);
`else
            OP_DIV:   res = FZERO;
`endif
            OP_SHIFT: res = fshift(a, b);
            OP_SLT:   res = fslt(a, b);
            OP_I2F:   res = i2f(b);
            OP_F2I:   res = f2i(b);
            default:  res = FZERO;
        endcase
    end
endmodule

// File: rtl/fpu_arbiter.sv
// Two-lane round-robin arbiter sequencing one shared float datapath.
// FPU_ARB_DIV_EN enables the two-pass divide (DIV2 state); otherwise div returns zero.
module fpu_arbiter
    import tacky_fpu_pkg::*;
#(
    parameter int LAT = LAT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [2:0]       op0,
    input  logic [FLOAT-1:0] a0,
    input  logic [FLOAT-1:0] b0,
    input  logic             req1,
    input  logic [2:0]       op1,
    input  logic [FLOAT-1:0] a1,
    input  logic [FLOAT-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [FLOAT-1:0] res0,
    output logic [FLOAT-1:0] res1,
    output logic             busy
);
`ifdef FPU_ARB_DIV_EN
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DIV2 = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1} state_t;
`endif

    state_t           state;
    logic [3:0]       cnt;
    logic             lane;
    logic             prefer1;
    logic [2:0]       op_q;
    logic [FLOAT-1:0] a_q;
    logic [FLOAT-1:0] b_q;
    logic [FLOAT-1:0] core_res;
`ifdef FPU_ARB_DIV_EN
    logic [FLOAT-1:0] recip_q;
`endif

    // prefer1 is set after lane 0 wins, so a tie goes to the lane not served last.
    assign gnt0 = !reset && (state == IDLE) && req0 && (!req1 || !prefer1);
    assign gnt1 = !reset && (state == IDLE) && req1 && (!req0 || prefer1);
    assign busy = !reset && (state != IDLE);

    fpu_core u_core (
        .op    (op_q),
        .a     (a_q),
        .b     (b_q),
`ifdef FPU_ARB_DIV_EN
        .div2  (state == DIV2),
        .recip (recip_q),
`endif
        .res   (core_res)
    );

    // Sequencer: capture on grant, count LAT per pass, publish result on the owning lane.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            lane    <= 1'b0;
            prefer1 <= 1'b0;
            op_q    <= 3'd0;
            a_q     <= FZERO;
            b_q     <= FZERO;
            done0   <= 1'b0;
            done1   <= 1'b0;
            res0    <= FZERO;
            res1    <= FZERO;
`ifdef FPU_ARB_DIV_EN
            recip_q <= FZERO;
`endif
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        lane    <= gnt1;
                        prefer1 <= gnt0;
                        op_q    <= gnt1 ? op1 : op0;
                        a_q     <= gnt1 ? a1 : a0;
                        b_q     <= gnt1 ? b1 : b0;
                        cnt     <= 4'(LAT);
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt != 4'd1) begin
                        cnt <= cnt - 4'd1;
`ifdef FPU_ARB_DIV_EN
                    end else if (op_q == OP_DIV) begin
                        recip_q <= core_res;
                        cnt     <= 4'(LAT);
                        state   <= DIV2;
`endif
                    end else begin
                        if (lane) begin done1 <= 1'b1; res1 <= core_res; end
                        else      begin done0 <= 1'b1; res0 <= core_res; end
                        state <= IDLE;
                    end
                end
`ifdef FPU_ARB_DIV_EN
                DIV2: begin
                    if (cnt != 4'd1) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (lane) begin done1 <= 1'b1; res1 <= core_res; end
                        else      begin done0 <= 1'b1; res0 <= core_res; end
                        state <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed bench for fpu_arbiter: three instances with LAT = 1, 2, 3.
// Divide expectations follow FPU_ARB_DIV_EN.
module tb_fpu_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        req0 [3], req1 [3], gnt0 [3], gnt1 [3];
    logic        done0 [3], done1 [3], busy [3];
    logic [2:0]  op0 [3], op1 [3];
    logic [15:0] a0 [3], b0 [3], a1 [3], b1 [3], res0 [3], res1 [3];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        fpu_arbiter #(.LAT(g + 1)) u_dut (
            .clk(clk), .reset(reset),
            .req0(req0[g]), .op0(op0[g]), .a0(a0[g]), .b0(b0[g]),
            .req1(req1[g]), .op1(op1[g]), .a1(a1[g]), .b1(b1[g]),
            .gnt0(gnt0[g]), .gnt1(gnt1[g]), .done0(done0[g]), .done1(done1[g]),
            .res0(res0[g]), .res1(res1[g]), .busy(busy[g])
        );
    end

    typedef struct packed {
        logic        lane;
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
    } vec_t;

    localparam vec_t VECS [14] = '{
        '{1'b0, 3'd0, 16'h3f80, 16'h3f80, 16'h4000},  // 1 + 1
        '{1'b0, 3'd0, 16'h4040, 16'h3f00, 16'h4060},  // 3 + 0.5
        '{1'b0, 3'd0, 16'h3f80, 16'hbf80, 16'h0000},  // 1 + -1
        '{1'b1, 3'd6, 16'h1234, 16'h0005, 16'h40a0},  // i2f 5
        '{1'b0, 3'd5, 16'h3f80, 16'h4000, 16'h0001},  // 1 < 2
        '{1'b0, 3'd5, 16'h4000, 16'h3f80, 16'h0000},  // 2 < 1
        '{1'b0, 3'd5, 16'hc000, 16'h3f80, 16'h0001},  // -2 < 1
        '{1'b0, 3'd7, 16'h0000, 16'h4780, 16'h7fff},  // f2i 65536 saturates
        '{1'b0, 3'd7, 16'h0000, 16'h4120, 16'h000a},  // f2i 10
        '{1'b0, 3'd7, 16'h0000, 16'hbf80, 16'h0000},  // f2i -1 saturates low
        '{1'b1, 3'd1, 16'h4040, 16'h3f80, 16'h4000},  // 3 - 1
        '{1'b1, 3'd4, 16'h3f80, 16'h0003, 16'h4100},  // 1 << 3
        '{1'b0, 3'd4, 16'h4000, 16'hffff, 16'h3f80},  // 2 >> 1
        '{1'b0, 3'd2, 16'h4040, 16'h4040, 16'h4110}   // 3 * 3
    };

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // One request on one lane; checks grant, done latency, result and other-lane hold.
    task automatic run_op(input string tag, input int g, input bit lane, input logic [2:0] op,
                          input logic [15:0] a, input logic [15:0] b,
                          input int want_cyc, input logic [15:0] want_res);
        int          c;
        bit          seen;
        bit          other_done;
        logic [15:0] other_res;
        other_res = lane ? res0[g] : res1[g];
        if (lane) begin req1[g] = 1'b1; op1[g] = op; a1[g] = a; b1[g] = b; end
        else      begin req0[g] = 1'b1; op0[g] = op; a0[g] = a; b0[g] = b; end
        @(negedge clk);
        chk({tag, " gnt"}, {31'd0, lane ? gnt1[g] : gnt0[g]}, 32'd1);
        @(posedge clk); #1;
        req0[g] = 1'b0; req1[g] = 1'b0;
        op0[g] = ~op; op1[g] = ~op; a0[g] = ~a; a1[g] = ~a; b0[g] = ~b; b1[g] = ~b;
        c = 1; seen = 1'b0; other_done = 1'b0;
        while (!seen && c < 40) begin
            @(negedge clk);
            other_done = other_done | (lane ? done0[g] : done1[g]);
            if (lane ? done1[g] : done0[g]) seen = 1'b1;
            else begin @(posedge clk); #1; c++; end
        end
        chk({tag, " done cycle"}, c, want_cyc);
        chk({tag, " res"}, lane ? res1[g] : res0[g], want_res);
        chk({tag, " other done"}, {31'd0, other_done}, 32'd0);
        chk({tag, " other res"}, lane ? res0[g] : res1[g], other_res);
        @(posedge clk); #1;
    endtask

    logic [6:0]  g0v, g1v, d0v, d1v, bv;
    logic [15:0] r0, r1;

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req0[i] = 1'b0; req1[i] = 1'b0; op0[i] = 3'd0; op1[i] = 3'd0;
            a0[i] = 16'h0000; b0[i] = 16'h0000; a1[i] = 16'h0000; b1[i] = 16'h0000;
        end
        repeat (3) @(posedge clk);
        #1;
        req0[0] = 1'b1;
        @(negedge clk);
        chk("reset gnt0", {31'd0, gnt0[0]}, 32'd0);
        chk("reset busy", {31'd0, busy[0]}, 32'd0);
        chk("reset done", {30'd0, done0[0], done1[0]}, 32'd0);
        chk("reset res0", res0[0], 32'd0);
        chk("reset res1", res1[0], 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; req0[0] = 1'b0;

        // Both lanes request a mul on the LAT=2 instance.
        req0[1] = 1'b1; op0[1] = 3'd2; a0[1] = 16'h4000; b0[1] = 16'h4040;
        req1[1] = 1'b1; op1[1] = 3'd2; a1[1] = 16'h4000; b1[1] = 16'h4040;
        r0 = 16'h0000; r1 = 16'h0000;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            g0v[c] = gnt0[1]; g1v[c] = gnt1[1]; d0v[c] = done0[1]; d1v[c] = done1[1]; bv[c] = busy[1];
            if (c == 3) r0 = res0[1];
            if (c == 6) r1 = res1[1];
            @(posedge clk); #1;
            if (g0v[c]) req0[1] = 1'b0;
            if (g1v[c]) req1[1] = 1'b0;
        end
        chk("rr gnt0 cycles", g0v, 7'b0000001);
        chk("rr gnt1 cycles", g1v, 7'b0001000);
        chk("rr done0 cycles", d0v, 7'b0001000);
        chk("rr done1 cycles", d1v, 7'b1000000);
        chk("rr busy cycles", bv, 7'b0110110);
        chk("rr res0", r0, 16'h40c0);
        chk("rr res1", r1, 16'h40c0);

        for (int i = 0; i < 14; i++)
            run_op($sformatf("vec%0d", i), 0, VECS[i].lane, VECS[i].op, VECS[i].a, VECS[i].b, 2, VECS[i].r);

`ifdef FPU_ARB_DIV_EN
        run_op("div", 0, 1'b1, 3'd3, 16'h40c0, 16'h4000, 3, 16'h4040);
`else
        run_op("div", 0, 1'b1, 3'd3, 16'h40c0, 16'h4000, 2, 16'h0000);
`endif

        // Abort a LAT=3 operation with reset in its first EXEC cycle.
        run_op("lat3 add", 2, 1'b0, 3'd0, 16'h3f80, 16'h3f80, 4, 16'h4000);
        req0[2] = 1'b1; op0[2] = 3'd0; a0[2] = 16'h4040; b0[2] = 16'h3f80;
        @(negedge clk);
        chk("abort gnt0", {31'd0, gnt0[2]}, 32'd1);
        @(posedge clk); #1;
        req0[2] = 1'b0; reset = 1'b1;
        @(negedge clk);
        chk("abort busy", {31'd0, busy[2]}, 32'd0);
        chk("abort done a", {30'd0, done0[2], done1[2]}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort res0", res0[2], 32'd0);
        chk("abort done b", {30'd0, done0[2], done1[2]}, 32'd0);
        chk("abort busy b", {31'd0, busy[2]}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_op("post reset sub", 2, 1'b0, 3'd1, 16'h4040, 16'h3f80, 4, 16'h4000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/fpu_arbiter.md
FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 Parameter LAT, default 1: cycles per float-unit pass; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0 / req1  input  1 each  lane 0 / lane 1 (left / right VLIW slot) operation request.
REQ-005 op0 / op1  input  3 each  opcode: 0 add, 1 sub, 2 mul, 3 div, 4 shift, 5 slt, 6 i2f, 7 f2i.
REQ-006 a0, b0 / a1, b1  input  16 each  operands (a = accumulator, b = register); must stay stable while req is high and gnt is low.
REQ-007 gnt0 / gnt1  output  1 each  combinational grant; operands are captured on the edge that ends the grant cycle.
REQ-008 done0 / done1  output  1 each  one-cycle result-valid pulse.
REQ-009 res0 / res1  output  16 each  lane result; holds its value until that lane's next done.
REQ-010 busy  output  1  high whenever the state is not IDLE.

Function
REQ-011 FSM states: IDLE, EXEC, DIV2; one shared float datapath serves both lanes.
REQ-012 In IDLE with any req high, exactly one gnt is asserted in that cycle, and the FSM moves to EXEC with the pass counter loaded to LAT.
REQ-013 Arbitration: round-robin; if both lanes request, grant the lane not granted last; a sole requester is always granted.
REQ-014 No gnt is asserted outside IDLE; requests are held by the requester, never queued.
REQ-015 Latency for single-pass ops (all except div): grant in cycle t; EXEC in t+1..t+LAT; done and res in cycle t+LAT+1, with state back in IDLE.
REQ-016 The done cycle is an IDLE cycle, so a new grant, to either lane, is legal in that same cycle.
REQ-017 div: EXEC pass computes r = recip(b) into an internal register; DIV2 pass (LAT cycles) computes a*r; done in cycle t+2*LAT+1.
REQ-018 sub = add(a, b ^ 16'h8000).
REQ-019 shift: float shift of a by signed integer b.
REQ-020 slt: res = 16'h0001 if float a < b, else 16'h0000.
REQ-021 i2f and f2i convert b; a is ignored.
REQ-022 Out-of-range f2i saturates to 32767 or 0, matching the team float library.
REQ-023 Only the granted lane's done and res change; the other lane's outputs hold.
REQ-024 Captured operands and opcode are immune to input changes after capture.

Reset
REQ-025 While reset is high: gnt0/1 = 0, done0/1 = 0, res0/1 = 16'h0000, busy = 0, state = IDLE, round-robin pointer favours lane 0.
REQ-026 Reset mid-operation aborts the operation with no done pulse; the first grant is possible in the first cycle after reset falls.

Configuration
REQ-027 With macro FPU_ARB_DIV_EN defined, div behaves per REQ-017.
REQ-028 Without FPU_ARB_DIV_EN:
- DIV2 state and the reciprocal table are omitted.
- op 3 is granted normally and completes as a single pass with res = 16'h0000, done at t+LAT+1.

Structure
REQ-029 Shared package tacky_fpu_pkg holds: op encodings, the FLOAT 16-bit width, FZERO / F32767 / F32768 constants, and the LAT default.
REQ-030 Sub-module fpu_core:
- combinational op-select over the team's fadd / fmul / frecip / fshift / fslt / i2f / f2i units;
- instantiated exactly once;
- fpu_arbiter holds all sequencing state.

Verification
REQ-031 LAT=1; req0 add a0=3f80 b0=3f80 -> gnt0 in cycle 0, done0 in cycle 2, res0=4000.
REQ-032 LAT=2; req0 and req1 both mul a=4000 b=4040 held -> gnt0 then gnt1; res0=40c0 in cycle 3; gnt1 in cycle 3; res1=40c0 in cycle 6.
REQ-033 FPU_ARB_DIV_EN, LAT=1; req1 div a1=40c0 b1=4000 -> done1 in cycle 3, res1=4040. Without the macro -> done1 in cycle 2, res1=0000.
REQ-034 req0 i2f b0=0005 -> res0=40a0. req0 slt a0=3f80 b0=4000 -> res0=0001. req0 f2i b0=4780 -> res0=7fff.
REQ-035 Reset asserted in cycle 1 of an EXEC with LAT=3 -> no done pulse, all outputs zero, busy low. req0 high after reset falls -> gnt0 in the first post-reset cycle.
